// File: rtl/our_multicycle_cpu.sv
// Multicycle RV32I-subset core (add/sub/and/or/slt/addi/lw/sw/beq).
// One instruction at a time: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}, with a sticky HALT state.
module our_multicycle_cpu #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halt
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LW, OP_SW, OP_BEQ} op_t;

  state_t          state;
  op_t             op;
  op_t             dec_op;
  logic            dec_ok;
  logic [31:0]     ir;
  logic [4:0]      rd;
  logic [XLEN-1:0] pc, opa, opb, imm, result;
  logic [XLEN-1:0] dec_imm, alu, alu_b;
  logic [XLEN-1:0] rf [NREGS];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;

  assign opcode = ir[6:0];
  assign rd_i   = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1_i  = ir[19:15];
  assign rs2_i  = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm_i  = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s  = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  assign imem_addr = pc;

  function automatic logic reg_ok(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // x0 is never written, but the guard also keeps out-of-range indices off the array.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || !reg_ok(idx)) return '0;
    return rf[idx[RW-1:0]];
  endfunction

  always_comb begin
    dec_op  = OP_ADD;
    dec_ok  = 1'b0;
    dec_imm = '0;
    case (opcode)
      7'b0110011: begin
        dec_ok = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec_op = OP_ADD;
          {7'h20, 3'b000}: dec_op = OP_SUB;
          {7'h00, 3'b111}: dec_op = OP_AND;
          {7'h00, 3'b110}: dec_op = OP_OR;
          {7'h00, 3'b010}: dec_op = OP_SLT;
          default:         dec_ok = 1'b0;
        endcase
        dec_ok = dec_ok && reg_ok(rd_i) && reg_ok(rs1_i) && reg_ok(rs2_i);
      end
      7'b0010011: begin
        dec_op  = OP_ADDI;
        dec_imm = imm_i;
        dec_ok  = (funct3 == 3'b000) && reg_ok(rd_i) && reg_ok(rs1_i);
      end
      7'b0000011: begin
        dec_op  = OP_LW;
        dec_imm = imm_i;
        dec_ok  = (funct3 == 3'b010) && reg_ok(rd_i) && reg_ok(rs1_i);
      end
      7'b0100011: begin
        dec_op  = OP_SW;
        dec_imm = imm_s;
        dec_ok  = (funct3 == 3'b010) && reg_ok(rs1_i) && reg_ok(rs2_i);
      end
      7'b1100011: begin
        dec_op  = OP_BEQ;
        dec_imm = imm_b;
        dec_ok  = (funct3 == 3'b000) && reg_ok(rs1_i) && reg_ok(rs2_i);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign alu_b = (op == OP_ADDI) ? imm : opb;

  always_comb begin
    alu = opa + alu_b;
    case (op)
      OP_SUB:  alu = opa - alu_b;
      OP_AND:  alu = opa & alu_b;
      OP_OR:   alu = opa | alu_b;
      OP_SLT:  alu = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(alu_b))};
      default: alu = opa + alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      halt       <= 1'b0;
      imem_req   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      op         <= OP_ADD;
      opa        <= '0;
      opb        <= '0;
      imm        <= '0;
      result     <= '0;
      rd         <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!dec_ok) begin
            halt  <= 1'b1;
            state <= S_HALT;
          end else begin
            op    <= dec_op;
            opa   <= rf_read(rs1_i);
            opb   <= rf_read(rs2_i);
            imm   <= dec_imm;
            rd    <= rd_i;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op)
            OP_BEQ: begin
              pc       <= (opa == opb) ? pc + imm : pc + XLEN'(4);
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_SW);
              dmem_addr  <= opa + imm;
              dmem_wdata <= opb;
              state      <= S_MEM;
            end
            default: begin
              result <= alu;
              state  <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              pc       <= pc + XLEN'(4);
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              result <= dmem_rdata;
              state  <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0) rf[rd[RW-1:0]] <= result;
          pc       <= pc + XLEN'(4);
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: begin
          halt     <= 1'b1;
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_our_multicycle_cpu.sv
// Bench for our_multicycle_cpu: ISA-level reference model predicts fetch addresses,
// data accesses and per-instruction latency; a memory responder inserts random wait states.
module tb_our_multicycle_cpu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        halt;

  logic        reset16 = 1'b1;
  logic        imem_req16, dmem_req16, dmem_we16, halt16;
  logic [31:0] imem_addr16, dmem_addr16, dmem_wdata16;

  our_multicycle_cpu u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .halt(halt)
  );

  // 16-register core fed a constant "addi x17,x0,1"
  our_multicycle_cpu #(.XLEN(32), .NREGS(16), .RESET_PC(32'h100)) u_dut16 (
    .clk(clk), .reset(reset16),
    .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_ready(1'b1), .imem_rdata(32'h0010_0893),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
    .dmem_ready(1'b0), .dmem_rdata(32'h0), .halt(halt16)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- memories and scoreboard ----------------
  logic [31:0] prog [256];
  logic [31:0] dmem_mem  [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  logic [31:0] exp_fetch_q[$];
  logic [31:0] exp_daddr_q[$];
  logic [31:0] exp_ddata_q[$];
  logic        exp_dwe_q[$];
  int          exp_lat_q[$];
  logic [31:0] fetch_log[$];

  bit scoring = 0, strict = 0, lat_check = 0, prev_valid = 0;
  int cyc = 0, prev_cyc = 0;
  int i_wmin = 0, i_wmax = 0, d_wmin = 0, d_wmax = 0;

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    if (addr[31:10] != 22'd0) return 32'h0000_007F;
    return prog[addr[9:2]];
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] im);
    return {im, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] im);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] im);
    return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] im);
    return enc_i(7'h13, 3'b000, rd, rs1, im);
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] im);
    return enc_i(7'h03, 3'b010, rd, rs1, im);
  endfunction

  task automatic prog_clear();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0000_007F;
  endtask

  // Architectural model: runs the program instruction by instruction.
  task automatic model_run(input int max_fetch);
    logic [31:0] r [32];
    logic [31:0] pc, ins, a, b, res, ii, is, ib, addr;
    logic [6:0]  f7;
    logic [2:0]  f3;
    bit          stop, wr;
    exp_fetch_q.delete(); exp_daddr_q.delete(); exp_ddata_q.delete();
    exp_dwe_q.delete(); exp_lat_q.delete(); model_mem.delete();
    for (int i = 0; i < 32; i++) r[i] = '0;
    pc = '0;
    for (int n = 0; n < max_fetch; n++) begin
      ins = imem_word(pc);
      exp_fetch_q.push_back(pc);
      a  = r[ins[19:15]];
      b  = r[ins[24:20]];
      f7 = ins[31:25];
      f3 = ins[14:12];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      stop = 0; wr = 0; res = '0;
      if (ins[6:0] == 7'h33) begin
        wr = 1;
        if (f7 == 7'h00 && f3 == 3'd0)      res = a + b;
        else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
        else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
        else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
        else if (f7 == 7'h00 && f3 == 3'd2) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else stop = 1;
        exp_lat_q.push_back(4);
      end else if (ins[6:0] == 7'h13 && f3 == 3'd0) begin
        wr = 1; res = a + ii;
        exp_lat_q.push_back(4);
      end else if (ins[6:0] == 7'h03 && f3 == 3'd2) begin
        addr = a + ii;
        exp_daddr_q.push_back(addr); exp_dwe_q.push_back(1'b0); exp_ddata_q.push_back('0);
        wr = 1; res = model_mem.exists(addr) ? model_mem[addr] : '0;
        exp_lat_q.push_back(5);
      end else if (ins[6:0] == 7'h23 && f3 == 3'd2) begin
        addr = a + is;
        exp_daddr_q.push_back(addr); exp_dwe_q.push_back(1'b1); exp_ddata_q.push_back(b);
        model_mem[addr] = b;
        exp_lat_q.push_back(4);
      end else if (ins[6:0] == 7'h63 && f3 == 3'd0) begin
        exp_lat_q.push_back(3);
      end else begin
        stop = 1;
      end
      if (stop) break;
      if (wr && ins[11:7] != 5'd0) r[ins[11:7]] = res;
      if (ins[6:0] == 7'h63) pc = (a == b) ? pc + ib : pc + 32'd4;
      else pc = pc + 32'd4;
    end
  endtask

  task automatic note_fetch(input logic [31:0] addr);
    fetch_log.push_back(addr);
    if (!scoring) return;
    if (strict) check("fetch_expected", 32'(exp_fetch_q.size() > 0), 32'd1);
    if (exp_fetch_q.size() > 0) check("fetch_addr", addr, exp_fetch_q.pop_front());
    if (lat_check && prev_valid && exp_lat_q.size() > 0)
      check("latency", 32'(cyc - prev_cyc), 32'(exp_lat_q.pop_front()));
    prev_cyc   = cyc;
    prev_valid = 1;
  endtask

  task automatic note_dmem(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    logic [31:0] ea;
    logic        ew;
    logic [31:0] ed;
    if (!scoring) return;
    check("dmem_expected", 32'(exp_daddr_q.size() > 0), 32'd1);
    if (exp_daddr_q.size() == 0) return;
    ea = exp_daddr_q.pop_front(); ew = exp_dwe_q.pop_front(); ed = exp_ddata_q.pop_front();
    check("dmem_addr", addr, ea);
    check("dmem_we", 32'(we), 32'(ew));
    if (ew) check("dmem_wdata", wdata, ed);
  endtask

  // ---------------- memory responder / monitor ----------------
  bit          i_pend = 0, d_pend = 0;
  int          i_wait = 0, d_wait = 0;
  logic [31:0] i_addr0, d_addr0, d_wdata0;
  logic        d_we0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      i_pend = 0; d_pend = 0; imem_ready = 1'b0; dmem_ready = 1'b0;
    end else begin
      check("req_exclusive", 32'(imem_req & dmem_req), 32'd0);
      if (imem_ready) imem_ready = 1'b0;
      else if (imem_req) begin
        if (!i_pend) begin
          i_pend = 1; i_wait = $urandom_range(i_wmax, i_wmin); i_addr0 = imem_addr;
        end else check("imem_addr_stable", imem_addr, i_addr0);
        if (i_wait == 0) begin
          imem_ready = 1'b1; imem_rdata = imem_word(imem_addr); i_pend = 0;
          note_fetch(imem_addr);
        end else i_wait--;
      end
      if (dmem_ready) dmem_ready = 1'b0;
      else if (dmem_req) begin
        if (!d_pend) begin
          d_pend = 1; d_wait = $urandom_range(d_wmax, d_wmin);
          d_addr0 = dmem_addr; d_we0 = dmem_we; d_wdata0 = dmem_wdata;
        end else begin
          check("dmem_addr_stable", dmem_addr, d_addr0);
          check("dmem_we_stable", 32'(dmem_we), 32'(d_we0));
          check("dmem_wdata_stable", dmem_wdata, d_wdata0);
        end
        if (d_wait == 0) begin
          dmem_ready = 1'b1; d_pend = 0;
          if (dmem_we) dmem_mem[dmem_addr] = dmem_wdata;
          else dmem_rdata = dmem_mem.exists(dmem_addr) ? dmem_mem[dmem_addr] : '0;
          note_dmem(dmem_addr, dmem_we, dmem_wdata);
        end else d_wait--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic reset_state_check();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd1);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
  endtask

  task automatic run_program(input int max_fetch, input bit expect_halt,
                             input int iw_max, input int dw_min, input int dw_max);
    int budget;
    model_run(max_fetch);
    fetch_log.delete(); dmem_mem.delete();
    i_wmin = 0; i_wmax = iw_max; d_wmin = dw_min; d_wmax = dw_max;
    lat_check  = (iw_max == 0 && dw_max == 0);
    prev_valid = 0;
    strict     = expect_halt;
    apply_reset();
    scoring = 1;
    budget  = 0;
    while (!(expect_halt ? (halt == 1'b1) : (exp_fetch_q.size() == 0)) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    check("run_timeout", 32'(budget >= 20000), 32'd0);
    if (expect_halt) begin
      repeat (3) begin
        @(negedge clk);
        check("halt_sticky", 32'(halt), 32'd1);
        check("halt_no_imem_req", 32'(imem_req), 32'd0);
        check("halt_no_dmem_req", 32'(dmem_req), 32'd0);
      end
      check("fetch_q_left", 32'(exp_fetch_q.size()), 32'd0);
      check("dmem_q_left", 32'(exp_daddr_q.size()), 32'd0);
    end
    scoring = 0;
  endtask

  task automatic gen_random_prog();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] im;
    int          sel, k;
    prog_clear();
    for (k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      im  = 12'($urandom);
      case (sel)
        0: prog[k] = enc_r(7'h00, 3'd0, rd, rs1, rs2);
        1: prog[k] = enc_r(7'h20, 3'd0, rd, rs1, rs2);
        2: prog[k] = enc_r(7'h00, 3'd7, rd, rs1, rs2);
        3: prog[k] = enc_r(7'h00, 3'd6, rd, rs1, rs2);
        4: prog[k] = enc_r(7'h00, 3'd2, rd, rs1, rs2);
        5, 6: prog[k] = addi(rd, rs1, im);
        7: prog[k] = lw(rd, ($urandom_range(0, 3) == 0) ? rs1 : 5'd0, 12'(32'h80 + 4 * $urandom_range(0, 7)));
        8: prog[k] = enc_s(rs2, ($urandom_range(0, 3) == 0) ? rs1 : 5'd0, 12'(32'h80 + 4 * $urandom_range(0, 7)));
        default: prog[k] = enc_b(rs1, ($urandom_range(0, 1) == 0) ? rs1 : rs2, 13'(4 * $urandom_range(1, 3)));
      endcase
    end
    // dump every register so the final architectural state is observed
    for (int i = 1; i < 32; i++) prog[39 + i] = enc_s(5'(i), 5'd0, 12'(32'h200 + 4 * i));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    repeat (3) @(posedge clk);
    reset_state_check();

    // arithmetic, x0 behaviour, store/load, taken branch, halt on opcode 0x7F
    prog_clear();
    prog[0]  = addi(5'd1, 5'd0, 12'd5);
    prog[1]  = addi(5'd2, 5'd0, 12'hFFD);
    prog[2]  = enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
    prog[3]  = enc_r(7'h20, 3'd0, 5'd4, 5'd2, 5'd1);
    prog[4]  = addi(5'd0, 5'd0, 12'd7);
    prog[5]  = enc_r(7'h00, 3'd0, 5'd6, 5'd0, 5'd0);
    prog[6]  = enc_s(5'd3, 5'd0, 12'h100);
    prog[7]  = enc_s(5'd4, 5'd0, 12'h104);
    prog[8]  = enc_s(5'd6, 5'd0, 12'h108);
    prog[9]  = lw(5'd7, 5'd0, 12'h104);
    prog[10] = enc_b(5'd7, 5'd4, 13'd8);
    prog[11] = addi(5'd8, 5'd0, 12'd1);
    prog[12] = enc_s(5'd7, 5'd0, 12'h10C);
    run_program(500, 1'b1, 0, 0, 0);
    check("x3_add", dmem_mem[32'h100], 32'd2);
    check("x4_sub", dmem_mem[32'h104], 32'hFFFF_FFF8);
    check("x6_x0_sum", dmem_mem[32'h108], 32'd0);
    check("x7_lw", dmem_mem[32'h10C], 32'hFFFF_FFF8);
    reset_state_check();

    // store then load with a 3-cycle data wait
    prog_clear();
    prog[0] = addi(5'd1, 5'd0, 12'd5);
    prog[1] = enc_s(5'd1, 5'd0, 12'd8);
    prog[2] = lw(5'd5, 5'd0, 12'd8);
    prog[3] = enc_s(5'd5, 5'd0, 12'h20);
    run_program(500, 1'b1, 0, 3, 3);
    check("sw_mem8", dmem_mem[32'h8], 32'd5);
    check("x5_lw_wait", dmem_mem[32'h20], 32'd5);

    // beq not taken at 0x20 falls through to 0x24
    prog_clear();
    prog[0] = addi(5'd1, 5'd0, 12'd5);
    prog[1] = addi(5'd2, 5'd0, 12'hFFD);
    for (int i = 2; i < 8; i++) prog[i] = addi(5'd0, 5'd0, 12'd0);
    prog[8] = enc_b(5'd1, 5'd2, 13'h1FF8);
    run_program(500, 1'b1, 1, 0, 0);
    check("beq_nt_count", 32'(fetch_log.size()), 32'd10);
    if (fetch_log.size() > 9) check("beq_nt_target", fetch_log[9], 32'h24);

    // beq taken backwards at 0x20 goes to 0x18 (loops; stop after a few fetches)
    prog[8] = enc_b(5'd1, 5'd1, 13'h1FF8);
    run_program(14, 1'b0, 0, 0, 0);
    check("beq_t_count", 32'(fetch_log.size() > 9), 32'd1);
    if (fetch_log.size() > 9) check("beq_t_target", fetch_log[9], 32'h18);

    // reset while a load is stalled in MEM
    prog_clear();
    prog[0] = lw(5'd1, 5'd0, 12'h40);
    i_wmax = 0; d_wmin = 10000; d_wmax = 10000;
    apply_reset();
    budget = 0;
    while (!dmem_req && budget < 100) begin @(negedge clk); budget++; end
    check("mem_reached", 32'(dmem_req), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mem_abort_dmem_req", 32'(dmem_req), 32'd0);
    check("mem_abort_imem_req", 32'(imem_req), 32'd1);
    check("mem_abort_pc", imem_addr, 32'd0);

    // random programs: zero-wait (latency checked) and with wait states
    for (int t = 0; t < 4; t++) begin
      gen_random_prog();
      if (t == 0) run_program(500, 1'b1, 0, 0, 0);
      else run_program(500, 1'b1, 2, 0, 3);
    end

    // 16-register core: rd=17 is illegal
    @(posedge clk); #1 reset16 = 1'b0;
    budget = 0;
    while (!halt16 && budget < 20) begin @(negedge clk); budget++; end
    repeat (3) begin
      @(negedge clk);
      check("r16_halt", 32'(halt16), 32'd1);
      check("r16_no_imem_req", 32'(imem_req16), 32'd0);
      check("r16_no_dmem_req", 32'(dmem_req16), 32'd0);
    end
    @(posedge clk); #1 reset16 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("r16_rst_addr", imem_addr16, 32'h100);
    check("r16_rst_req", 32'(imem_req16), 32'd1);
    check("r16_rst_halt", 32'(halt16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
